// File: rtl/palette_load_ctrl_if.sv
// Palette load controller bus: user/frame/colour inputs towards the
// controller and the slot-load strobe bus back out to the palette slots.
interface palette_load_ctrl_if #(
  parameter int COLOR_W = 24
);
  logic               swap_in;
  logic               frame_start_in;
  logic [COLOR_W-1:0] color_in;
  logic [3:0]         load_en_out;
  logic [COLOR_W-1:0] load_color_out;
  logic [1:0]         slot_ptr_out;
  logic               pending_out;

  // Controller side.
  modport master (
    input  swap_in,
    input  frame_start_in,
    input  color_in,
    output load_en_out,
    output load_color_out,
    output slot_ptr_out,
    output pending_out
  );

  // Environment side (button, video timing, colour source, slot registers).
  modport slave (
    output swap_in,
    output frame_start_in,
    output color_in,
    input  load_en_out,
    input  load_color_out,
    input  slot_ptr_out,
    input  pending_out
  );
endinterface

// File: rtl/palette_load_ctrl.sv
// Palette load controller.
// Debounces the swap button, captures the free-running colour on each
// press and commits it to the next palette slot (round robin) only at a
// frame boundary, so the visible picture never changes mid-frame.
// Also holds a small checker module with the output invariants.
module palette_load_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int COLOR_W         = 24
) (
  input  logic                clk_in,
  input  logic                reset_in,
  palette_load_ctrl_if.master bus
);

  // Counter only has to reach DEBOUNCE_CYCLES-1 (DEBOUNCE_CYCLES >= 2).
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ARMED  = 2'b01,
    ST_COMMIT = 2'b10
  } state_t;

  // Slot number to one-hot load strobe.
  function automatic logic [3:0] slot_onehot(input logic [1:0] slot);
    case (slot)
      2'd0:    return 4'b0001;
      2'd1:    return 4'b0010;
      2'd2:    return 4'b0100;
      2'd3:    return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  logic               sync1_r;
  logic               sync2_r;
  logic               deb_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               press_r;
  state_t             state_r;
  logic [COLOR_W-1:0] hold_r;
  logic               again_r;
  logic [3:0]         load_en_r;
  logic [COLOR_W-1:0] load_color_r;
  logic [1:0]         slot_ptr_r;
  logic               pending_r;

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= bus.swap_in;
      sync2_r <= sync1_r;
    end
  end

  // Debounce: accept a new level after DEBOUNCE_CYCLES consecutive
  // differing samples; flag a one-cycle press on an accepted rise.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      deb_r   <= 1'b0;
      cnt_r   <= CNT_ZERO;
      press_r <= 1'b0;
    end else begin
      press_r <= 1'b0;
      if (sync2_r != deb_r) begin
        if (cnt_r == CNT_LAST) begin
          deb_r   <= sync2_r;
          cnt_r   <= CNT_ZERO;
          press_r <= sync2_r;
        end else begin
          cnt_r <= cnt_r + CNT_ONE;
        end
      end else begin
        cnt_r <= CNT_ZERO;
      end
    end
  end

  // Capture / arm / commit sequencer with registered slot-load outputs.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_r      <= ST_IDLE;
      hold_r       <= {COLOR_W{1'b0}};
      again_r      <= 1'b0;
      load_en_r    <= 4'b0000;
      load_color_r <= {COLOR_W{1'b0}};
      slot_ptr_r   <= 2'd0;
      pending_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // Frame boundaries are irrelevant until something is captured.
          if (press_r) begin
            hold_r    <= bus.color_in;
            pending_r <= 1'b1;
            state_r   <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          // Later presses simply overwrite the held colour.
          if (press_r) begin
            hold_r    <= bus.color_in;
            pending_r <= 1'b1;
          end
          // The commit takes the colour held before this cycle's press;
          // a colliding press stays pending for the next frame.
          if (bus.frame_start_in) begin
            load_color_r <= hold_r;
            load_en_r    <= slot_onehot(slot_ptr_r);
            again_r      <= press_r;
            state_r      <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          load_en_r  <= 4'b0000;
          slot_ptr_r <= slot_ptr_r + 2'd1;
          again_r    <= 1'b0;
          if (press_r) begin
            hold_r <= bus.color_in;
          end
          if (again_r || press_r) begin
            state_r <= ST_ARMED;
          end else begin
            state_r   <= ST_IDLE;
            pending_r <= 1'b0;
          end
        end
        default: begin
          // Unreachable encoding: drop any strobe and fall back to idle.
          state_r   <= ST_IDLE;
          load_en_r <= 4'b0000;
          again_r   <= 1'b0;
          pending_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.load_en_out    = load_en_r;
  assign bus.load_color_out = load_color_r;
  assign bus.slot_ptr_out   = slot_ptr_r;
  assign bus.pending_out    = pending_r;

endmodule

// Output invariants of the palette load controller.
module palette_load_ctrl_chk #(
  parameter int COLOR_W = 24
) (
  input logic               clk_in,
  input logic               reset_in,
  input logic [3:0]         load_en,
  input logic [COLOR_W-1:0] load_color
);

  // The strobe never selects more than one slot.
  a_load_en_onehot0: assert property (
    @(posedge clk_in) disable iff (reset_in) $onehot0(load_en)
  );

  // The commit colour only moves together with a strobe.
  a_color_stable: assert property (
    @(posedge clk_in) disable iff (reset_in)
      $changed(load_color) |-> (load_en != 4'b0000)
  );

endmodule

// File: doc/palette_load_ctrl.md
Name: palette_load_ctrl

Overview:
Sequences loading of the four 24-bit palette slot registers in the VGA colour application. It debounces the user swap button and captures the free-running generated colour on each press. The captured colour is committed to the next slot in round-robin order, but only at a frame boundary, so the visible picture never changes mid-frame. It replaces the ad-hoc state machine and 2-to-4 decoder that currently drive the slot register clocks.

Parameters:
DEBOUNCE_CYCLES, 250000, consecutive stable cycles of the synchronized button needed to accept a level change (10 ms at 25 MHz); minimum 2
COLOR_W, 24, colour width

Ports:
clk_in  in  1  pixel clock
reset_in  in  1  reset; asynchronous, active-high
swap_in  in  1  raw user button, active-high, asynchronous to clk_in
frame_start_in  in  1  one-cycle pulse at start of vertical blanking
color_in  in  COLOR_W  free-running generated colour
load_en_out  in/out: out  4  one-hot slot load strobe, one cycle wide
load_color_out  out  COLOR_W  colour to write into the strobed slot
slot_ptr_out  out  2  slot that the next commit will write
pending_out  out  1  a captured colour is waiting for a frame boundary

Behaviour:
- Reset (async, active-high) clears every register: 2-FF synchronizer = 0, debounced level = 0, debounce counter = 0, state = IDLE, slot_ptr_out = 0, load_en_out = 0, load_color_out = 0, hold register = 0, pending_out = 0.
- Reset asserted mid-COMMIT aborts that commit. The slot pointer does not advance and no strobe is emitted.
- Synchronizer: swap_in passes through 2 flops, giving sync_sw.
- Debounce:
  - Whenever sync_sw differs from the debounced level, the counter increments; otherwise it clears to 0.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level takes sync_sw and the counter clears.
  - Any bounce before that clears the counter.
- Press event: a one-cycle internal pulse on the debounced 0->1 edge. Release edges produce no event.
  - A button held through reset release yields exactly one press event, DEBOUNCE_CYCLES+2 cycles after reset deasserts.
- Press latency: a clean swap_in rise produces the press event DEBOUNCE_CYCLES+2 cycles later.
- On each press event: hold <= color_in (same cycle value) and pending_out <= 1.
- FSM states: IDLE, ARMED, COMMIT.
  - IDLE: a press event goes to ARMED. frame_start_in is ignored.
  - ARMED, press event without frame_start_in: hold is recaptured (latest press wins). No extra commit is scheduled; stay in ARMED.
  - ARMED with frame_start_in: load_color_out <= hold and load_en_out <= one-hot(slot_ptr_out) on the next edge; go to COMMIT.
  - ARMED with press and frame_start_in in the same cycle: the commit uses the previously held colour. The new colour goes into hold and stays pending.
  - COMMIT (exactly 1 cycle): load_en_out is asserted. On exit, load_en_out <= 0 and slot_ptr_out <= slot_ptr_out+1 (3 wraps to 0).
  - COMMIT exit: next state is ARMED if a press arrived in ARMED-with-frame_start or in COMMIT; otherwise IDLE with pending_out <= 0.
- Commit latency: load_en_out rises 1 cycle after the frame_start_in pulse that it consumes.
- Frame limit: at most one commit per frame_start_in. Presses beyond one per frame merge (latest colour wins).
- Invariants:
  - load_en_out is always zero or one-hot.
  - load_color_out is stable outside COMMIT and changes only on ARMED->COMMIT.

Test Plan:
(DEBOUNCE_CYCLES=4 in sim)
- Reset: pulse reset_in with the clock stopped -> all outputs 0 immediately; slot_ptr_out=0.
- Clean press: color_in=0x123456 at the press event, then frame_start_in 20 cycles later -> load_en_out=4'b0001 for exactly 1 cycle, load_color_out=0x123456, then slot_ptr_out=1 and pending_out=0.
- Bounce: swap_in toggles every 2 cycles for 20 cycles, then held high -> exactly one press event, 6 cycles after the final rise.
- Round-robin: 5 press/frame pairs with colours A..E -> strobes 0001, 0010, 0100, 1000, 0001 carry A..E; slot_ptr_out wraps 3->0.
- Merge and collision:
  - Presses capture 0xAA0000 then 0x00BB00 before a frame -> a single commit of 0x00BB00.
  - A press (0x0000CC) in the same cycle as frame_start_in while ARMED -> the current frame commits the old colour; the next frame_start_in commits 0x0000CC.
- Reset mid-commit: assert reset_in during the COMMIT cycle -> load_en_out drops asynchronously, slot_ptr_out=0, pending_out=0, and no later strobe occurs without a new press.
